// File: rtl/prefetch_queue_pkg.sv
// prefetch_queue_pkg: constants, FSM encoding and address helper shared by the prefetch queue.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// RST_CS/RST_IP are also the register file's reset values, so the first fetch matches the
// architectural reset vector.
package prefetch_queue_pkg;

  localparam logic [15:0] PQ_RST_CS  = 16'hf000;
  localparam logic [15:0] PQ_RST_IP  = 16'hfff0;
  localparam int          PQ_QDEPTH  = 6;

  // IDLE: no bus cycle; FETCH: bus cycle whose data will be kept;
  // DRAIN: bus cycle made stale by a flush, data is discarded on ack.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } pq_state_t;

  // Segment:offset to word-aligned 20-bit physical address (wraps at 1 MiB).
  function automatic logic [19:0] phys_word_adr(input logic [15:0] seg, input logic [15:0] off);
    return ({seg, 4'h0} + {4'h0, off}) & 20'hffffe;
  endfunction

endpackage

// File: rtl/pq_byte_fifo.sv
// pq_byte_fifo: circular byte store with 1- or 2-byte write, 1-byte pop and sync clear.
// Latency: written bytes appear on rd_dat/count the cycle after the write.
// Backpressure: none internal; the writer only writes when count leaves room for the bytes.
// Ports: clk, rst (async active-low), clr (sync clear, wins over write/pop),
//        wr_en/wr_two/wr_dat (two bytes: [7:0] then [15:8]; one byte: [15:8] only),
//        rd_en (ignored when empty), rd_dat (byte at read pointer), count (bytes held).
module pq_byte_fifo #(
  parameter int DEPTH = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        wr_en,
  input  logic        wr_two,
  input  logic [15:0] wr_dat,
  input  logic        rd_en,
  output logic [7:0]  rd_dat,
  output logic [2:0]  count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [PW-1:0] wr_nx;
  logic [2:0]    count_q;
  logic [2:0]    n_wr;
  logic [2:0]    n_rd;
  logic          do_pop;

  // Pointers wrap DEPTH-1 -> 0; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = rd_en && (count_q != 3'd0);
  assign wr_nx  = ptr_inc(wr_q);
  assign n_wr   = wr_en ? (wr_two ? 3'd2 : 3'd1) : 3'd0;
  assign n_rd   = do_pop ? 3'd1 : 3'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (clr) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        if (wr_two) begin
          mem[wr_q]  <= wr_dat[7:0];
          mem[wr_nx] <= wr_dat[15:8];
          wr_q       <= ptr_inc(wr_nx);
        end else begin
          mem[wr_q]  <= wr_dat[15:8];
          wr_q       <= wr_nx;
        end
      end
      if (do_pop) begin
        rd_q <= ptr_inc(rd_q);
      end
      count_q <= count_q + n_wr - n_rd;
    end
  end

  assign rd_dat = mem[rd_q];
  assign count  = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// prefetch_queue: 8086-style prefetch queue; fetches 16-bit words at cs:fp into a byte queue.
// Latency: request 1 cycle after space appears; acked bytes visible to the decoder next cycle.
// Backpressure: fetch stalls while free space < bytes needed; mem_stb held until mem_ack.
// Ports: clk, rst (async active-low); cs/ip/flush from the register file (sampled on flush);
//        mem_adr/mem_stb/mem_ack/mem_dat_i fetch bus; q_byte/q_valid/q_pop/q_ip/q_count decoder side.
// QDEPTH must be in 2..7 so that q_count fits its 3-bit port.
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int          QDEPTH = PQ_QDEPTH,
  parameter logic [15:0] RST_CS = PQ_RST_CS,
  parameter logic [15:0] RST_IP = PQ_RST_IP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cs,
  input  logic [15:0] ip,
  input  logic        flush,
  output logic [19:0] mem_adr,
  output logic        mem_stb,
  input  logic        mem_ack,
  input  logic [15:0] mem_dat_i,
  output logic [7:0]  q_byte,
  output logic        q_valid,
  input  logic        q_pop,
  output logic [15:0] q_ip,
  output logic [2:0]  q_count
);

  pq_state_t   state_q;
  pq_state_t   state_d;
  logic [15:0] fp_q;
  logic [15:0] cs_q;
  logic [15:0] q_ip_q;
  logic [19:0] adr_q;
  logic [2:0]  count;
  logic [3:0]  need;
  logic [3:0]  free;
  logic        has_space;
  logic        issue;
  logic        accept;

  // An odd fetch offset only yields its high byte, so it needs a single free slot.
  assign need      = fp_q[0] ? 4'd1 : 4'd2;
  // Registered count: a pop in this cycle does not open space until the next one.
  assign free      = 4'(QDEPTH) - {1'b0, count};
  assign has_space = (free >= need);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!flush && has_space) begin
          state_d = ST_FETCH;
          issue   = 1'b1;
        end
      end
      ST_FETCH: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
          accept  = !flush;
        end else if (flush) begin
          // The bus cycle cannot be aborted; let it finish and throw the data away.
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      fp_q    <= RST_IP;
      cs_q    <= RST_CS;
      q_ip_q  <= RST_IP;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        adr_q <= phys_word_adr(cs_q, fp_q);
      end
      if (flush) begin
        fp_q   <= ip;
        cs_q   <= cs;
        q_ip_q <= ip;
      end else begin
        // fp wraps ffff -> 0 within the segment.
        if (accept) begin
          fp_q <= fp_q + 16'(need);
        end
        if (q_pop && q_valid) begin
          q_ip_q <= q_ip_q + 16'd1;
        end
      end
    end
  end

  pq_byte_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .wr_en  (accept),
    .wr_two (!fp_q[0]),
    .wr_dat (mem_dat_i),
    .rd_en  (q_pop && !flush),
    .rd_dat (q_byte),
    .count  (count)
  );

  assign mem_stb = (state_q != ST_IDLE);
  assign mem_adr = adr_q;
  assign q_valid = (count != 3'd0);
  assign q_count = count;
  assign q_ip    = q_ip_q;

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- 8086-style instruction prefetch queue sitting directly downstream of the register file.
- On flush it takes cs and ip from the register file and becomes the fetch pointer source.
- Fetches 16-bit words from memory into a 6-byte circular queue.
- Presents bytes, plus the offset of the head byte, to the decoder one per cycle.

Parameters:
- QDEPTH, 6: queue capacity in bytes; must be ≥2.
- RST_CS, 16'hf000: segment value loaded at reset.
- RST_IP, 16'hfff0: offset value loaded at reset.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cs  input  16  code segment from the register file; sampled only on flush.
- ip  input  16  instruction pointer from the register file; sampled only on flush.
- flush  input  1  discard the queue and restart fetching at cs:ip.
- mem_adr  output  20  word-aligned physical byte address; bit 0 is always 0.
- mem_stb  output  1  fetch request; held until mem_ack.
- mem_ack  input  1  data valid on mem_dat_i; completes the request.
- mem_dat_i  input  16  fetched word, little-endian (low byte at the even address).
- q_byte  output  8  head byte; valid when q_valid=1.
- q_valid  output  1  queue not empty.
- q_pop  input  1  consume the head byte this cycle.
- q_ip  output  16  offset of the head byte.
- q_count  output  3  bytes held, 0..QDEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - queue empty: q_count=0, q_valid=0, q_byte=0
  - rd/wr pointers =0
  - fp (fetch offset)=RST_IP, cs_q=RST_CS, q_ip=RST_IP
  - mem_stb=0, mem_adr=0, state IDLE
- Physical address: phys = ({cs_q,4'b0} + {4'b0,fp}) mod 2^20; mem_adr = {phys[19:1],1'b0}.
- Request size: need = fp[0] ? 1 : 2 bytes.
- FSM states and transitions:
  - IDLE: if !flush and (QDEPTH−q_count) ≥ need → FETCH. mem_stb=1 and mem_adr valid from the next cycle, so issue latency is 1 cycle. Otherwise stay in IDLE.
  - FETCH: mem_stb=1, mem_adr stable until mem_ack.
    - On mem_ack without flush: if fp[0]=0, write mem_dat_i[7:0] at wr and [15:8] at wr+1, fp += 2. If fp[0]=1, write only [15:8], fp += 1. Then go to IDLE.
    - On flush with no ack this cycle → DRAIN.
  - DRAIN: mem_stb stays 1 because a bus cycle is never aborted. On mem_ack the data is dropped → IDLE.
- Flush:
  - queue cleared, fp←ip, cs_q←cs, q_ip←ip.
  - Flush in the same cycle as mem_ack: the data is dropped and the FSM goes to IDLE.
  - Flush in the same cycle as q_pop: flush wins and the pop is ignored.
- Pop:
  - If q_pop and q_valid: rd advances, q_ip += 1 (16-bit wrap).
  - Pop when empty is ignored.
  - Pop and ack in the same cycle: both apply, count = count − 1 + bytes written.
- Wrap rules:
  - rd/wr pointers wrap QDEPTH−1→0.
  - fp wraps 16'hffff→0 (segment wrap).
  - phys wraps at 2^20.
  - fp=16'hffff fetches one high byte, then fp=0.
- Outputs are registered except q_byte, which is the storage read at rd, and q_valid = (q_count≠0).
- Space check uses the registered q_count, so a same-cycle pop does not grant extra space.

Decomposition:
- Shared package holds:
  - RST_CS/RST_IP constants, which are also used by the register file reset.
  - queue depth.
  - FSM state encoding: IDLE/FETCH/DRAIN.
- Sub-module pq_byte_fifo: QDEPTH-byte circular store with 1- or 2-byte write, 1-byte pop, sync clear, and count.
- Top level holds the FSM, fp/cs_q/q_ip, and address generation.

Test Plan:
- Reset release, mem_ack tied to respond 1 cycle after stb → cycle 1: mem_stb=1, mem_adr=20'hffff0. Ack 16'h1234 → q_byte=8'h34, q_ip=16'hfff0, q_count=2. Pop → q_byte=8'h12, q_ip=16'hfff1.
- No pops, acks return 16'h1111, 16'h2222, 16'h3333 → q_count=6, mem_stb stays 0. A single pop does not restart fetch (need=2, free=1); a second pop restarts fetch.
- Flush with cs=16'h1000, ip=16'h0003 → mem_adr=20'h10002. Ack 16'hABCD → only 8'hAB enqueued with q_ip=16'h0003. Next mem_adr=20'h10004.
- Flush while in FETCH, ack 2 cycles later with 16'hDEAD → nothing enqueued, q_count=0. Next request at the new cs:ip.
- Flush cs=16'hffff, ip=16'hfffe → mem_adr=20'h0ffee, fp becomes 0. Next mem_adr=20'hffff0.
- q_count=4, q_pop and mem_ack (even fp) in the same cycle → q_count=5, q_ip incremented by 1.
